// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states and the
// 2-of-3 majority vote used for bit sampling.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head entry is visible on
// rdata_o whenever empty_o is low. A push into a full FIFO only lands if a pop
// frees a slot in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver feeding a FWFT receive FIFO with per-frame
// parity, framing and break tags plus a sticky overrun flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OSR        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic                          baud_tick,
  input  logic                          rxd,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_perr,
  output logic                          rx_ferr,
  output logic                          rx_break,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          clr_ovr
);

  localparam int OC_W = $clog2(OSR);
  localparam int EW   = DATA_BITS + 3;
  localparam logic [OC_W-1:0] OC_S0  = OC_W'(OSR/2 - 1);
  localparam logic [OC_W-1:0] OC_S1  = OC_W'(OSR/2);
  localparam logic [OC_W-1:0] OC_DEC = OC_W'(OSR/2 + 1);
  localparam logic [OC_W-1:0] OC_END = OC_W'(OSR - 1);

  logic                 sync1_q, rxs_q;
  rx_state_e            state_q;
  logic [OC_W-1:0]      oc_q;
  logic [3:0]           bcnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 smp0_q, smp1_q, par_bit_q;
  logic                 perr_q, ferr_q, brk_q, push_q;
  logic [EW-1:0]        entry_q, head;
  logic                 maj, wrap, last_data, last_stop, par_exp;
  logic                 ferr_now, brk_now, full, empty, ovr_set;

  assign maj       = majority3(smp0_q, smp1_q, rxs_q);
  assign wrap      = (oc_q == OC_END);
  assign last_data = (bcnt_q == 4'(DATA_BITS - 1));
  assign last_stop = (bcnt_q == 4'(STOP_BITS - 1));
  assign par_exp   = (PARITY == PAR_ODD) ? ~(^shift_q) : ^shift_q;
  assign ferr_now  = ferr_q | ~maj;
  // Break is judged on the first stop bit; later stop bits only add ferr.
  assign brk_now   = (bcnt_q == '0)
                   ? ((shift_q == '0) && ((PARITY == PAR_NONE) || !par_bit_q) && !maj)
                   : brk_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rxs_q   <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_IDLE;
      oc_q    <= '0;
      bcnt_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      push_q  <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (baud_tick) begin
        if (state_q == ST_IDLE) begin
          if (!rxs_q) begin
            state_q <= ST_START;
            oc_q    <= '0;
            bcnt_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
          end
        end else begin
          oc_q <= wrap ? '0 : oc_q + 1'b1;
          case (state_q)
            ST_START: begin
              if (oc_q == OC_DEC && maj) state_q <= ST_IDLE;
              else if (wrap)             state_q <= ST_DATA;
            end
            ST_DATA: begin
              if (wrap) begin
                if (last_data) begin
                  bcnt_q  <= '0;
                  state_q <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end else begin
                  bcnt_q <= bcnt_q + 1'b1;
                end
              end
            end
            ST_PARITY: begin
              if (oc_q == OC_DEC) perr_q <= (maj != par_exp);
              if (wrap) state_q <= ST_STOP;
            end
            ST_STOP: begin
              // Leave at the last decision point so a following start edge is not missed.
              if (oc_q == OC_DEC) begin
                ferr_q <= ferr_now;
                brk_q  <= brk_now;
                if (last_stop) begin
                  push_q  <= 1'b1;
                  state_q <= ST_IDLE;
                end
              end
              if (wrap) bcnt_q <= bcnt_q + 1'b1;
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (baud_tick && state_q != ST_IDLE) begin
      if (oc_q == OC_S0) smp0_q <= rxs_q;
      if (oc_q == OC_S1) smp1_q <= rxs_q;
      if (oc_q == OC_DEC) begin
        if (state_q == ST_DATA)   shift_q   <= {maj, shift_q[DATA_BITS-1:1]};
        if (state_q == ST_PARITY) par_bit_q <= maj;
        if (state_q == ST_STOP && last_stop)
          entry_q <= {brk_now, ferr_now, perr_q, shift_q};
      end
    end
  end

  assign ovr_set = push_q && full && !rd_en;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)        overrun <= 1'b0;
    else if (ovr_set) overrun <= 1'b1;
    else if (clr_ovr) overrun <= 1'b0;
  end

  uart_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .clrn    (clrn),
    .push_i  (push_q),
    .pop_i   (rd_en),
    .wdata_i (entry_q),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  assign rx_valid = !empty;
  assign rx_data  = head[DATA_BITS-1:0];
  assign rx_perr  = head[DATA_BITS];
  assign rx_ferr  = head[DATA_BITS+1];
  assign rx_break = head[DATA_BITS+2];

endmodule
